// File: rtl/param_dataram.sv
// rtl/param_dataram.sv - parametrised data RAM with init sequencer, read strobe, ready and out-of-window flag
module param_dataram #(
    parameter int DW    = 8,
    parameter int AW    = 5,
    parameter int DEPTH = 8,
    parameter int BASE  = 24,
    parameter logic [DEPTH*DW-1:0] INIT_VEC =
        {8'h01, 8'h01, 8'h00, 8'h0A, 8'h01, 8'h00, 8'h00, 8'h00}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          READ,
    input  logic          WRITE,
    input  logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_DIN,
    output logic [DW-1:0] MEM_DOUT,
    output logic          rd_valid,
    output logic          ready,
    output logic          oob
);

    // Counter wide enough to index every storage word.
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Window bounds held one bit wider than the address so BASE+DEPTH == 2**AW fits.
    localparam logic [AW:0]   WIN_LO   = (AW+1)'(BASE);
    localparam logic [AW:0]   WIN_HI   = (AW+1)'(BASE + DEPTH);
    localparam logic [AW-1:0] BASE_A   = AW'(BASE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          rd_valid_q, rd_valid_d;
    logic          oob_q, oob_d;

    logic [DW-1:0] mem [DEPTH];

    logic          mem_we;
    logic [CW-1:0] mem_widx;
    logic [DW-1:0] mem_wdata;

    logic          in_win;
    logic [CW-1:0] win_idx;

    // Address decode: window membership and word index relative to BASE.
    always_comb begin
        in_win  = ({1'b0, MEM_ADDR} >= WIN_LO) && ({1'b0, MEM_ADDR} < WIN_HI);
        win_idx = CW'(MEM_ADDR - BASE_A);
    end

    // Next-state logic: init sequencing, request arbitration (clear > READ > WRITE).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        oob_d      = oob_q;
        mem_we     = 1'b0;
        mem_widx   = cnt_q;
        mem_wdata  = INIT_VEC[int'(cnt_q)*DW +: DW];

        case (state_q)
            S_INIT: begin
                if (clear) begin
                    cnt_d = '0;
                end else begin
                    mem_we = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RUN: begin
                if (clear) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else if (READ) begin
                    dout_d     = in_win ? mem[win_idx] : '0;
                    rd_valid_d = 1'b1;
                    oob_d      = ~in_win;
                end else if (WRITE) begin
                    oob_d = ~in_win;
                    if (in_win) begin
                        mem_we    = 1'b1;
                        mem_widx  = win_idx;
                        mem_wdata = MEM_DIN;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            oob_q      <= oob_d;
        end
    end

    // Storage array: contents are only meaningful after the init sequence, so no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign MEM_DOUT = dout_q;
    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;
    assign oob      = oob_q;

endmodule

// File: tb/tb_param_dataram.sv
// tb/tb_param_dataram.sv - self-checking bench for param_dataram
module tb_param_dataram;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rd_valid;
    logic       ready;
    logic       oob;

    always #5 clk = ~clk;

    param_dataram dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .READ     (rd),
        .WRITE    (wr),
        .MEM_ADDR (addr),
        .MEM_DIN  (din),
        .MEM_DOUT (dout),
        .rd_valid (rd_valid),
        .ready    (ready),
        .oob      (oob)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: variable map by absolute address, ready by countdown of init edges.
    logic [7:0] img [8];
    logic [7:0] mm [32];
    int         m_left;
    logic       m_rdy;
    logic [7:0] m_dout;
    logic       m_valid;
    logic       m_oob;

    task automatic m_reset();
        m_left  = 8;
        m_rdy   = 1'b0;
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_oob   = 1'b0;
    endtask

    task automatic m_edge(input logic c, input logic r, input logic w,
                          input logic [4:0] a, input logic [7:0] d);
        bit inwin;
        inwin   = (a >= 5'd24);
        m_valid = 1'b0;
        if (!m_rdy) begin
            if (c) m_left = 8;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_rdy = 1'b1;
                    for (int i = 0; i < 8; i++) mm[24+i] = img[i];
                end
            end
        end else if (c) begin
            m_rdy  = 1'b0;
            m_left = 8;
        end else if (r) begin
            m_dout  = inwin ? mm[a] : 8'h00;
            m_valid = 1'b1;
            m_oob   = !inwin;
        end else if (w) begin
            if (inwin) mm[a] = d;
            m_oob = !inwin;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".dout"},  {24'h0, dout},    {24'h0, m_dout});
        chk({tag, ".valid"}, {31'h0, rd_valid}, {31'h0, m_valid});
        chk({tag, ".ready"}, {31'h0, ready},    {31'h0, m_rdy});
        chk({tag, ".oob"},   {31'h0, oob},      {31'h0, m_oob});
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge, advance the model.
    task automatic step(input logic c, input logic r, input logic w,
                        input logic [4:0] a, input logic [7:0] d);
        clear = c; rd = r; wr = w; addr = a; din = d;
        @(posedge clk);
        #1;
        m_edge(c, r, w, a, d);
        clear = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    typedef struct {
        logic       r;
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] e_dout;
        logic       e_v;
        logic       e_o;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a,
                                input logic [7:0] d, input logic [7:0] e_dout,
                                input logic e_v, input logic e_o);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d;
        v.e_dout = e_dout; v.e_v = e_v; v.e_o = e_o;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        img = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h0A, 8'h00, 8'h01, 8'h01};

        tbl[0]  = mk(1'b1, 1'b0, 5'd26, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 5'd27, 8'h00, 8'h01, 1'b1, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 5'd28, 8'h00, 8'h0A, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 5'd29, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 5'd30, 8'h00, 8'h01, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 5'd31, 8'h00, 8'h01, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 5'd29, 8'h37, 8'h01, 1'b0, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 5'd29, 8'h00, 8'h37, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 5'd28, 8'h00, 8'h0A, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 5'd3,  8'h00, 8'h00, 1'b1, 1'b1);
        tbl[10] = mk(1'b0, 1'b1, 5'd5,  8'hFF, 8'h00, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 5'd24, 8'h00, 8'h00, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 5'd30, 8'h55, 8'h01, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b0, 5'd30, 8'h00, 8'h01, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 5'd0,  8'h00, 8'h01, 1'b0, 1'b0);

        reset = 1'b1; clear = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_model("reset");

        // Init length: ready only after the 8th edge.
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'd26, 8'h00);
            chk($sformatf("init_ready[%0d]", i), {31'h0, ready}, {31'h0, (i == 7)});
            chk($sformatf("init_valid[%0d]", i), {31'h0, rd_valid}, 32'h0);
        end

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            step(1'b0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl[%0d].dout", i),  {24'h0, dout},     {24'h0, tbl[i].e_dout});
            chk($sformatf("tbl[%0d].valid", i), {31'h0, rd_valid}, {31'h0, tbl[i].e_v});
            chk($sformatf("tbl[%0d].oob", i),   {31'h0, oob},      {31'h0, tbl[i].e_o});
            chk($sformatf("tbl[%0d].ready", i), {31'h0, ready},    32'h1);
        end

        // Clear with a read on the same edge, requests ignored while re-initialising.
        step(1'b0, 1'b0, 1'b1, 5'd31, 8'hAA);
        chk_model("wr31");
        step(1'b1, 1'b1, 1'b0, 5'd31, 8'h00);
        chk("clr_ready", {31'h0, ready}, 32'h0);
        chk("clr_valid", {31'h0, rd_valid}, 32'h0);
        chk("clr_dout_hold", {24'h0, dout}, 32'h01);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'(i % 2), 1'((i + 1) % 2), 5'(24 + i), 8'hC3);
            chk($sformatf("reinit_ready[%0d]", i), {31'h0, ready}, 32'h0);
            chk($sformatf("reinit_valid[%0d]", i), {31'h0, rd_valid}, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        chk("reinit_ready_up", {31'h0, ready}, 32'h1);
        step(1'b0, 1'b1, 1'b0, 5'd31, 8'h00);
        chk("reinit_rd31", {24'h0, dout}, 32'h01);
        chk_model("reinit");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic c, r, w;
            logic [4:0] a;
            c = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 31));
            step(c, r, w, a, 8'($urandom));
            chk_model($sformatf("rnd[%0d]", i));
        end
        for (int a = 24; a < 32; a++) begin
            step(1'b0, 1'b1, 1'b0, 5'(a), 8'h00);
            chk_model($sformatf("rnd_sweep[%0d]", a));
        end

        // Reset in the middle of init.
        reset = 1'b1;
        #1;
        m_reset();
        chk_model("areset_run");
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        reset = 1'b1;
        #1;
        m_reset();
        chk_model("areset_midinit");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
            chk($sformatf("reinit2_ready[%0d]", i), {31'h0, ready}, {31'h0, (i == 7)});
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'(26 + i), 8'h00);
            chk($sformatf("post_reset_rd[%0d]", 26 + i), {24'h0, dout}, {24'h0, img[2+i]});
            chk($sformatf("post_reset_v[%0d]", 26 + i), {31'h0, rd_valid}, 32'h1);
            chk($sformatf("post_reset_o[%0d]", 26 + i), {31'h0, oob}, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
